msrv32_wb_stage_unit: RTL and testbench
=======================================

Name: msrv32_wb_stage_unit

Overview:
Registered, parametrised writeback stage for the msrv32 core; successor to the purely combinational writeback mux.
- Selects one of NUM_SRC result sources into an XLEN-bit writeback value and registers the register-file write (data, rd, enable).
- Stalls the pipeline while a load result is outstanding.
- Keeps the ALU second-operand mux (rs2 vs immediate) as a combinational sideband.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 8, number of writeback sources (source index = select code)
SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC
RF_AW, 5, register-file address width
LOAD_SEL, 1, select code identifying the load-unit source
MAX_WAIT, 15, load-wait cycles before timeout error

Ports:
ms_riscv32_mp_clk_in  input  1  clock
ms_riscv32_mp_rst_in  input  1  synchronous active-high reset
valid_in  input  1  instruction present in WB stage this cycle
wb_mux_sel_reg_in  input  SEL_W  source select
src_data_in  input  NUM_SRC*XLEN  flattened sources; slot k = bits [k*XLEN +: XLEN]
rf_wr_en_reg_in  input  1  instruction writes rd
rd_addr_reg_in  input  RF_AW  destination register
lu_valid_in  input  1  load-unit data valid (slot LOAD_SEL)
rs2_reg_in  input  XLEN  rs2 operand
imm_reg_in  input  XLEN  immediate
alu_source_reg_in  input  1  0 = rs2, 1 = immediate
wb_mux_out  output  XLEN  registered writeback data
rf_wr_en_out  output  1  registered register-file write strobe
rd_addr_out  output  RF_AW  registered destination
stall_out  output  1  hold upstream stages
wb_timeout_out  output  1  sticky load-timeout flag
alu_2nd_src_mux_out  output  XLEN  combinational: alu_source_reg_in ? imm_reg_in : rs2_reg_in

Behaviour:
- Reset (synchronous, active-high, takes priority over every other input): wb_mux_out=0, rf_wr_en_out=0, rd_addr_out=0, wait counter=0, wb_timeout_out=0, state=PASS. stall_out is 0 because it is decoded from state.
- Clock and reset are one clock, ms_riscv32_mp_clk_in, and one synchronous active-high reset, ms_riscv32_mp_rst_in. Both are fixed.
- Select: a select code >= NUM_SRC selects slot 0 (the ALU result).
- Write enable and the x0 rule: rf_wr_en_out is registered as valid & rf_wr_en_reg_in & (rd != 0). With rd=0 the data register still updates, but no write strobe is issued.
- Latency: 1 cycle from input to registered outputs. rf_wr_en_out is a single-cycle pulse per retired instruction.
- State PASS:
  - If valid_in, the select is LOAD_SEL and lu_valid_in=0: go to WAIT. Capture rd and the write enable internally, assert no write, clear the counter.
  - Otherwise: register the selected data.
- State WAIT:
  - stall_out=1, combinationally from state; valid_in and the select are ignored.
  - On lu_valid_in=1: register the load data with the captured rd and write enable, then return to PASS. stall_out drops in the same cycle the write strobe rises.
  - When the counter reaches MAX_WAIT without lu_valid_in: set wb_timeout_out (sticky until reset), drop the write, return to PASS.
  - If lu_valid_in arrives in the same cycle the counter hits MAX_WAIT, the data wins and no timeout is flagged.
- Load already valid in PASS: completes with no stall.
- Reset mid-WAIT: aborts, with no write and no stall on the next cycle.
- alu_2nd_src_mux_out is purely combinational; it is unaffected by reset or stall.

Optional Feature:
WB_FWD_EN
- Defined: adds output fwd_valid_out (1) and fwd_data_out (XLEN). These expose the value and rd being written in the current cycle for forwarding to decode, and equal wb_mux_out / rd_addr_out whenever rf_wr_en_out=1. Adds output fwd_rd_out (RF_AW).
- Undefined: these ports are absent and there is no forwarding logic.

Decomposition:
- Package msrv32_pkg:
  - WB select code localparams: ALU=0, LOAD=1, IMM=2, IADDER=3, CSR=4, PC4=5.
  - The XLEN default.
  - State encoding: PASS=1'b0, WAIT=1'b1.
- One sub-module, msrv32_wb_src_mux: the parametrised combinational N:1 select with the out-of-range default. The FSM, counter and registers stay in the top module.

Test Plan:
- Pass-through: sel=0, ALU src=32'hA5A5A5A5, rd=5, valid → next cycle wb_mux_out=A5A5A5A5, rf_wr_en_out=1, rd_addr_out=5, stall_out=0.
- Select sweep: sel 0..5 with distinct sources (12345678, FFFF0000, 98765432, BCDEF012, 13579BDF); sel=6 and sel=7 → output equals slot 0.
- x0 suppression: rd=0, sel=2, imm=FFFF0000 → wb_mux_out=FFFF0000, rf_wr_en_out=0.
- Load wait:
  - Stimulus: sel=1, lu_valid_in=0 for 3 cycles, then 1 with data 12345678.
  - Response: stall_out high for exactly 3 cycles; a single write of 12345678 to the captured rd.
- Timeout: sel=1, lu_valid_in held 0 → after MAX_WAIT=15 cycles wb_timeout_out=1 (sticky), no write, stall_out=0. A simultaneous lu_valid_in at count 15 → write occurs and no timeout.
- Reset in WAIT, plus ALU operand mux:
  - Reset asserted in WAIT → all outputs 0 the next cycle.
  - alu_source_reg_in=0/1 → alu_2nd_src_mux_out=2468ACE0 / imm, during stall as well.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 writeback stage: select codes, datapath default and FSM encoding.
package msrv32_pkg;

  localparam int XLEN_DEF = 32;

  localparam int WB_SEL_ALU    = 0;
  localparam int WB_SEL_LOAD   = 1;
  localparam int WB_SEL_IMM    = 2;
  localparam int WB_SEL_IADDER = 3;
  localparam int WB_SEL_CSR    = 4;
  localparam int WB_SEL_PC4    = 5;

  typedef enum logic {
    PASS = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_wb_src_mux.sv
// Parametrised N:1 writeback source select; codes at or beyond NUM_SRC fall back to slot 0 (ALU).
module msrv32_wb_src_mux
  import msrv32_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3
) (
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_SRC*XLEN-1:0] src_data_in,
  output logic [XLEN-1:0]         data_out
);

  always_comb begin
    data_out = src_data_in[0 +: XLEN];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (sel_in == SEL_W'(k)) begin
        data_out = src_data_in[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/msrv32_wb_stage_unit.sv
// Registered writeback stage with load-wait stall, sticky timeout and the ALU operand-2 mux.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module msrv32_wb_stage_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_SRC  = 8,
  parameter int SEL_W    = 3,
  parameter int RF_AW    = 5,
  parameter int LOAD_SEL = WB_SEL_LOAD,
  parameter int MAX_WAIT = 15
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic                    valid_in,
  input  logic [SEL_W-1:0]        wb_mux_sel_reg_in,
  input  logic [NUM_SRC*XLEN-1:0] src_data_in,
  input  logic                    rf_wr_en_reg_in,
  input  logic [RF_AW-1:0]        rd_addr_reg_in,
  input  logic                    lu_valid_in,
  input  logic [XLEN-1:0]         rs2_reg_in,
  input  logic [XLEN-1:0]         imm_reg_in,
  input  logic                    alu_source_reg_in,
  output logic [XLEN-1:0]         wb_mux_out,
  output logic                    rf_wr_en_out,
  output logic [RF_AW-1:0]        rd_addr_out,
  output logic                    stall_out,
  output logic                    wb_timeout_out,
`ifdef WB_FWD_EN
  output logic                    fwd_valid_out,
  output logic [XLEN-1:0]         fwd_data_out,
  output logic [RF_AW-1:0]        fwd_rd_out,
`endif
  output logic [XLEN-1:0]         alu_2nd_src_mux_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  wb_state_e        state_q, state_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic             wr_en_q, wr_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [RF_AW-1:0] cap_rd_q, cap_rd_d;
  logic             cap_we_q, cap_we_d;

  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  load_data;
  logic             load_miss;

  msrv32_wb_src_mux #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .sel_in      (wb_mux_sel_reg_in),
    .src_data_in (src_data_in),
    .data_out    (sel_data)
  );

  assign load_data = src_data_in[LOAD_SEL*XLEN +: XLEN];
  assign load_miss = valid_in && (wb_mux_sel_reg_in == SEL_W'(LOAD_SEL)) && !lu_valid_in;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rd_d      = rd_q;
    wr_en_d   = 1'b0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    cap_rd_d  = cap_rd_q;
    cap_we_d  = cap_we_q;
    case (state_q)
      PASS: begin
        if (load_miss) begin
          state_d  = WAIT;
          cap_rd_d = rd_addr_reg_in;
          cap_we_d = rf_wr_en_reg_in;
          cnt_d    = '0;
        end else begin
          data_d  = sel_data;
          rd_d    = rd_addr_reg_in;
          wr_en_d = valid_in && rf_wr_en_reg_in && (rd_addr_reg_in != '0);
        end
      end
      WAIT: begin
        // Load data arriving on the final wait cycle still wins over the timeout.
        if (lu_valid_in) begin
          state_d = PASS;
          data_d  = load_data;
          rd_d    = cap_rd_q;
          wr_en_d = cap_we_q && (cap_rd_q != '0);
        end else if (cnt_q + CNT_W'(1) == CNT_W'(MAX_WAIT)) begin
          state_d   = PASS;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q   <= PASS;
      data_q    <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      cap_rd_q  <= '0;
      cap_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      cap_rd_q  <= cap_rd_d;
      cap_we_q  <= cap_we_d;
    end
  end

  assign wb_mux_out          = data_q;
  assign rf_wr_en_out        = wr_en_q;
  assign rd_addr_out         = rd_q;
  assign stall_out           = (state_q == WAIT);
  assign wb_timeout_out      = timeout_q;
  assign alu_2nd_src_mux_out = alu_source_reg_in ? imm_reg_in : rs2_reg_in;

`ifdef WB_FWD_EN
  assign fwd_valid_out = wr_en_q;
  assign fwd_data_out  = data_q;
  assign fwd_rd_out    = rd_q;
`endif

endmodule

// File: tb/tb_msrv32_wb_stage_unit.sv
// Self-checking bench for msrv32_wb_stage_unit: directed scenarios pinned by literals, then random traffic
// checked every cycle against a transaction-level model of the writeback stage.
module tb_msrv32_wb_stage_unit;

  localparam int XLEN     = 32;
  localparam int NUM_SRC  = 6;
  localparam int SEL_W    = 3;
  localparam int RF_AW    = 5;
  localparam int LOAD_SEL = 1;
  localparam int MAX_WAIT = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic [SEL_W-1:0]        sel_in;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic                    we_in;
  logic [RF_AW-1:0]        rd_in;
  logic                    lu_valid;
  logic [XLEN-1:0]         rs2_in;
  logic [XLEN-1:0]         imm_in;
  logic                    alu_src;
  logic [XLEN-1:0]         wb_mux_out;
  logic                    rf_wr_en_out;
  logic [RF_AW-1:0]        rd_addr_out;
  logic                    stall_out;
  logic                    wb_timeout_out;
  logic [XLEN-1:0]         alu_2nd_src_mux_out;
`ifdef WB_FWD_EN
  logic                    fwd_valid_out;
  logic [XLEN-1:0]         fwd_data_out;
  logic [RF_AW-1:0]        fwd_rd_out;
`endif

  always #5 clk = ~clk;

  msrv32_wb_stage_unit #(
    .XLEN     (XLEN),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .RF_AW    (RF_AW),
    .LOAD_SEL (LOAD_SEL),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .valid_in             (valid_in),
    .wb_mux_sel_reg_in    (sel_in),
    .src_data_in          (src_data),
    .rf_wr_en_reg_in      (we_in),
    .rd_addr_reg_in       (rd_in),
    .lu_valid_in          (lu_valid),
    .rs2_reg_in           (rs2_in),
    .imm_reg_in           (imm_in),
    .alu_source_reg_in    (alu_src),
    .wb_mux_out           (wb_mux_out),
    .rf_wr_en_out         (rf_wr_en_out),
    .rd_addr_out          (rd_addr_out),
    .stall_out            (stall_out),
    .wb_timeout_out       (wb_timeout_out),
`ifdef WB_FWD_EN
    .fwd_valid_out        (fwd_valid_out),
    .fwd_data_out         (fwd_data_out),
    .fwd_rd_out           (fwd_rd_out),
`endif
    .alu_2nd_src_mux_out  (alu_2nd_src_mux_out)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction-level model: what the register file should see, plus whether a load is outstanding.
  logic [XLEN-1:0]  m_data;
  logic [RF_AW-1:0] m_rd;
  bit               m_wr;
  bit               m_pending;
  bit               m_timeout;
  int               m_waited;
  logic [RF_AW-1:0] m_cap_rd;
  bit               m_cap_we;

  function automatic logic [XLEN-1:0] slotOf(int k);
    return src_data[k*XLEN +: XLEN];
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate();
    if (rst) begin
      m_data = '0; m_rd = '0; m_wr = 0; m_pending = 0; m_timeout = 0; m_waited = 0;
      m_cap_rd = '0; m_cap_we = 0;
      return;
    end
    m_wr = 0;
    if (m_pending) begin
      m_waited++;
      if (lu_valid) begin
        m_pending = 0;
        m_data    = slotOf(LOAD_SEL);
        m_rd      = m_cap_rd;
        m_wr      = m_cap_we && (m_cap_rd != 0);
      end else if (m_waited == MAX_WAIT) begin
        m_pending = 0;
        m_timeout = 1;
      end
    end else if (valid_in && int'(sel_in) == LOAD_SEL && !lu_valid) begin
      m_pending = 1;
      m_waited  = 0;
      m_cap_rd  = rd_in;
      m_cap_we  = we_in;
    end else begin
      m_data = slotOf((int'(sel_in) < NUM_SRC) ? int'(sel_in) : 0);
      m_rd   = rd_in;
      m_wr   = valid_in && we_in && (rd_in != 0);
    end
  endtask

  task automatic checkOutput();
    checkVal("wb_mux_out",     wb_mux_out,     m_data);
    checkVal("rf_wr_en_out",   rf_wr_en_out,   m_wr);
    checkVal("rd_addr_out",    rd_addr_out,    m_rd);
    checkVal("stall_out",      stall_out,      m_pending);
    checkVal("wb_timeout_out", wb_timeout_out, m_timeout);
    checkVal("alu_2nd_src",    alu_2nd_src_mux_out, alu_src ? imm_in : rs2_in);
`ifdef WB_FWD_EN
    checkVal("fwd_valid_out", fwd_valid_out, m_wr);
    if (m_wr) begin
      checkVal("fwd_data_out", fwd_data_out, m_data);
      checkVal("fwd_rd_out",   fwd_rd_out,   m_rd);
    end
`endif
  endtask

  task automatic step();
    modelUpdate();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(bit v, int sel, bit we, int rd, bit lu);
    valid_in = v;
    sel_in   = SEL_W'(sel);
    we_in    = we;
    rd_in    = RF_AW'(rd);
    lu_valid = lu;
    step();
  endtask

  int stall_cnt;
  int wr_cnt;

  initial begin
    rst = 1; valid_in = 0; sel_in = '0; we_in = 0; rd_in = '0; lu_valid = 0;
    rs2_in = 32'h2468ACE0; imm_in = 32'h0F0F1234; alu_src = 0;
    src_data = {32'h13579BDF, 32'hBCDEF012, 32'h98765432, 32'hFFFF0000, 32'h12345678, 32'hA5A5A5A5};

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkVal("reset_wb", wb_mux_out, 0);
    checkVal("reset_stall", stall_out, 0);
    rst = 0;

    applyStimulus(1, 0, 1, 5, 0);
    checkVal("pass_data", wb_mux_out, 32'hA5A5A5A5);
    checkVal("pass_wr", rf_wr_en_out, 1);
    checkVal("pass_rd", rd_addr_out, 5);
    checkVal("pass_stall", stall_out, 0);

    for (int s = 0; s < 8; s++) applyStimulus(1, s, 1, s + 1, 1);
    checkVal("sel7_slot0", wb_mux_out, 32'hA5A5A5A5);
    applyStimulus(1, 4, 1, 3, 0);
    checkVal("sel4_csr", wb_mux_out, 32'hBCDEF012);
    applyStimulus(1, 6, 1, 3, 0);
    checkVal("sel6_slot0", wb_mux_out, 32'hA5A5A5A5);

    applyStimulus(1, 2, 1, 0, 0);
    checkVal("x0_data", wb_mux_out, 32'hFFFF0000);
    checkVal("x0_wr", rf_wr_en_out, 0);

    // Load wait: three stalled cycles, then a single write to the captured rd.
    stall_cnt = 0; wr_cnt = 0;
    applyStimulus(1, 1, 1, 7, 0);
    stall_cnt += int'(stall_out); wr_cnt += int'(rf_wr_en_out);
    alu_src = 1;
    applyStimulus(1, 0, 1, 9, 0);
    stall_cnt += int'(stall_out); wr_cnt += int'(rf_wr_en_out);
    checkVal("alu_mux_in_stall", alu_2nd_src_mux_out, 32'h0F0F1234);
    alu_src = 0;
    applyStimulus(1, 3, 0, 2, 0);
    stall_cnt += int'(stall_out); wr_cnt += int'(rf_wr_en_out);
    checkVal("alu_mux_rs2_stall", alu_2nd_src_mux_out, 32'h2468ACE0);
    applyStimulus(0, 0, 0, 0, 1);
    stall_cnt += int'(stall_out); wr_cnt += int'(rf_wr_en_out);
    checkVal("load_data", wb_mux_out, 32'h12345678);
    checkVal("load_rd", rd_addr_out, 7);
    applyStimulus(0, 0, 0, 0, 0);
    stall_cnt += int'(stall_out); wr_cnt += int'(rf_wr_en_out);
    checkVal("load_stall_cycles", stall_cnt, 3);
    checkVal("load_single_write", wr_cnt, 1);

    // Timeout: no load data for MAX_WAIT cycles.
    stall_cnt = 0;
    applyStimulus(1, 1, 1, 9, 0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      stall_cnt += int'(stall_out);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkVal("timeout_stall_cycles", stall_cnt, MAX_WAIT);
    checkVal("timeout_flag", wb_timeout_out, 1);
    checkVal("timeout_no_wr", rf_wr_en_out, 0);
    checkVal("timeout_stall_drop", stall_out, 0);
    applyStimulus(1, 0, 1, 4, 0);
    checkVal("timeout_sticky", wb_timeout_out, 1);
    rst = 1; applyStimulus(0, 0, 0, 0, 0); rst = 0;

    // Load data on the last permitted wait cycle beats the timeout.
    applyStimulus(1, 1, 1, 12, 0);
    for (int i = 0; i < MAX_WAIT - 1; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkVal("late_load_wr", rf_wr_en_out, 1);
    checkVal("late_load_rd", rd_addr_out, 12);
    checkVal("late_load_no_timeout", wb_timeout_out, 0);

    // Reset while waiting aborts the load.
    applyStimulus(1, 1, 1, 6, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1; applyStimulus(0, 0, 0, 0, 1); rst = 0;
    checkVal("rst_wait_wr", rf_wr_en_out, 0);
    checkVal("rst_wait_stall", stall_out, 0);
    checkVal("rst_wait_data", wb_mux_out, 0);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rs2_in   = $urandom;
      imm_in   = $urandom;
      alu_src  = $urandom_range(0, 1);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31), $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
